edp_mdstep_ctl: RTL and testbench

Multiply/divide step sequencer for the EBOX data path. It holds the EDP for a fixed number of shift/add steps. Each cycle it drives the AD function select and the AR/ARX/BR/MQ strobes that CTL would otherwise derive from CRAM. It sits between CTL and the EDP, and owns the EDP from accepting `start` until it issues `done` or is aborted.

---
 rtl/edp_mdstep_ctl.sv | 159 +++++++++++++++
 tb/tb_edp_mdstep_ctl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edp_mdstep_ctl.sv
// edp_mdstep_ctl: multiply/divide step sequencer that drives EDP AD select and register strobes.
// Define EDP_MDSTEP_DIV_EN to build the non-restoring divide path; without it a DIV request is rejected on err.
module edp_mdstep_ctl #(
   parameter int STEPS = 36
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       op,
   input  logic       abort,
   input  logic       mq35,
   input  logic       ad_neg,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] ad_fn,
   output logic       br_load,
   output logic       ar_clr,
   output logic       ar_load,
   output logic       arx_load,
   output logic       mq_shift,
   output logic [5:0] step
);

   generate
      if (STEPS < 2 || STEPS > 63) begin : g_bad_steps
         $error("edp_mdstep_ctl: STEPS=%0d is outside 2..63", STEPS);
      end
   endgenerate

   localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

`ifdef EDP_MDSTEP_DIV_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_FIXUP, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_DONE} state_t;
`endif

   state_t     state;
   state_t     state_nxt;
   logic [5:0] step_q;
   logic [1:0] step_fn;
   logic       accept;

`ifdef EDP_MDSTEP_DIV_EN
   logic op_q;
   logic neg_q;

   assign accept = start;
   assign err    = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= 1'b0;
         neg_q <= 1'b0;
      end else begin
         if (state == S_IDLE && start) op_q <= op;
         if (state == S_STEP) neg_q <= ad_neg;
      end
   end

   // Non-restoring divide: subtract unless the previous partial remainder went negative.
   always_comb begin
      if (!op_q)
         step_fn = {1'b0, mq35};
      else if (step_q == 6'd0 || !neg_q)
         step_fn = 2'd2;
      else
         step_fn = 2'd1;
   end
`else
   logic err_q;
   logic unused_ad_neg;

   // AD sign only matters to the divide path, which is not built here.
   assign unused_ad_neg = ad_neg;
   assign accept        = start & ~op;
   assign step_fn       = {1'b0, mq35};
   assign err           = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= (state == S_IDLE) && start && op;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Cleared while idle so LOAD and the first STEP both present index 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                step_q <= 6'd0;
      else if (state == S_STEP)  step_q <= step_q + 6'd1;
      else if (state == S_IDLE)  step_q <= 6'd0;
   end

   always_comb begin
      state_nxt = state;
      ad_fn     = 2'd0;
      br_load   = 1'b0;
      ar_clr    = 1'b0;
      ar_load   = 1'b0;
      arx_load  = 1'b0;
      mq_shift  = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            br_load   = 1'b1;
            ar_clr    = 1'b1;
            state_nxt = S_STEP;
         end
         S_STEP: begin
            ar_load  = 1'b1;
            arx_load = 1'b1;
            mq_shift = 1'b1;
            ad_fn    = step_fn;
            if (step_q == LAST_STEP) begin
`ifdef EDP_MDSTEP_DIV_EN
               state_nxt = (op_q && ad_neg) ? S_FIXUP : S_DONE;
`else
               state_nxt = S_DONE;
`endif
            end
         end
`ifdef EDP_MDSTEP_DIV_EN
         S_FIXUP: begin
            ad_fn     = 2'd1;
            ar_load   = 1'b1;
            state_nxt = S_DONE;
         end
`endif
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      // Abort releases the EDP within the same cycle; IDLE and DONE are not abortable.
      if (abort && state != S_IDLE && state != S_DONE) begin
         ad_fn     = 2'd0;
         br_load   = 1'b0;
         ar_clr    = 1'b0;
         ar_load   = 1'b0;
         arx_load  = 1'b0;
         mq_shift  = 1'b0;
         state_nxt = S_IDLE;
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);
   assign step = step_q;

endmodule

// File: tb/tb_edp_mdstep_ctl.sv
// Directed bench for edp_mdstep_ctl with STEPS=4; inputs change 1ns after posedge, outputs sampled 2ns after.
`timescale 1ns/1ps
module tb_edp_mdstep_ctl;
   localparam int STEPS = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic op = 1'b0;
   logic abort = 1'b0;
   logic mq35 = 1'b0;
   logic ad_neg = 1'b0;
   logic busy, done, err, br_load, ar_clr, ar_load, arx_load, mq_shift;
   logic [1:0] ad_fn;
   logic [5:0] step;
   logic [4:0] strb;

   int vectors = 0;
   int miscompares = 0;
   int unsigned cyc = 0;

   assign strb = {br_load, ar_clr, ar_load, arx_load, mq_shift};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   edp_mdstep_ctl #(.STEPS(STEPS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .abort(abort),
      .mq35(mq35), .ad_neg(ad_neg), .busy(busy), .done(done), .err(err),
      .ad_fn(ad_fn), .br_load(br_load), .ar_clr(ar_clr), .ar_load(ar_load),
      .arx_load(arx_load), .mq_shift(mq_shift), .step(step)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if ({busy, done, err} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags: busy/done/err=%b want 000", {busy, done, err});
      end
      vectors++;
      if ({ad_fn, strb, step} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: ad_fn=%0d strb=%b step=%0d want all 0", ad_fn, strb, step);
      end
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      #1;
      vectors++;
      if (busy !== 1'b0 || strb !== 5'd0) begin
         miscompares++;
         $display("FAIL idle_after_reset: busy=%b strb=%b want 0 00000", busy, strb);
      end
   endtask

   task automatic test_mul();
      logic [3:0] pat;
      int unsigned t0;
      int nstrb;
      pat = 4'b1101;
      nstrb = 0;
      start = 1'b1; op = 1'b0;
      t0 = cyc;
      next_cycle();
      start = 1'b0;
      #1;
      vectors++;
      if (strb !== 5'b11000 || busy !== 1'b1 || step !== 6'd0) begin
         miscompares++;
         $display("FAIL mul_load: strb=%b busy=%b step=%0d want 11000 1 0", strb, busy, step);
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         mq35 = pat[i];
         #1;
         if (ar_load || arx_load || mq_shift) nstrb++;
         vectors++;
         if (ad_fn !== {1'b0, pat[i]} || step !== 6'(i)) begin
            miscompares++;
            $display("FAIL mul_step%0d: ad_fn=%0d step=%0d want %0d %0d", i, ad_fn, step, pat[i], i);
         end
      end
      next_cycle();
      mq35 = 1'b0;
      #1;
      if (ar_load || arx_load || mq_shift) nstrb++;
      vectors++;
      if (done !== 1'b1 || strb !== 5'd0 || (cyc - t0) !== 6) begin
         miscompares++;
         $display("FAIL mul_done: done=%b strb=%b latency=%0d want 1 00000 6", done, strb, cyc - t0);
      end
      next_cycle();
      #1;
      if (ar_load || arx_load || mq_shift) nstrb++;
      vectors++;
      if (nstrb !== 4 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL mul_strobe_count: count=%0d busy=%b done=%b want 4 0 0", nstrb, busy, done);
      end
   endtask

`ifdef EDP_MDSTEP_DIV_EN
   task automatic test_div();
      logic [3:0] negs;
      logic [1:0] exp_fn [4];
      int unsigned t0;
      negs = 4'b1010;
      exp_fn[0] = 2'd2; exp_fn[1] = 2'd2; exp_fn[2] = 2'd1; exp_fn[3] = 2'd2;
      start = 1'b1; op = 1'b1;
      t0 = cyc;
      next_cycle();
      start = 1'b0; op = 1'b0;
      #1;
      vectors++;
      if (strb !== 5'b11000 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL div_load: strb=%b err=%b want 11000 0", strb, err);
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         ad_neg = negs[i];
         #1;
         vectors++;
         if (ad_fn !== exp_fn[i] || strb !== 5'b00111) begin
            miscompares++;
            $display("FAIL div_step%0d: ad_fn=%0d strb=%b want %0d 00111", i, ad_fn, strb, exp_fn[i]);
         end
      end
      next_cycle();
      ad_neg = 1'b0;
      #1;
      vectors++;
      if (ad_fn !== 2'd1 || strb !== 5'b00100 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL div_fixup: ad_fn=%0d strb=%b done=%b want 1 00100 0", ad_fn, strb, done);
      end
      next_cycle();
      #1;
      vectors++;
      if (done !== 1'b1 || (cyc - t0) !== 7) begin
         miscompares++;
         $display("FAIL div_done: done=%b latency=%0d want 1 7", done, cyc - t0);
      end
      next_cycle();
   endtask
`else
   task automatic test_div_disabled();
      start = 1'b1; op = 1'b1;
      #1;
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL div_rej_early: err=%b want 0", err);
      end
      next_cycle();
      start = 1'b0; op = 1'b0;
      #1;
      vectors++;
      if (err !== 1'b1 || busy !== 1'b0 || strb !== 5'd0) begin
         miscompares++;
         $display("FAIL div_rej: err=%b busy=%b strb=%b want 1 0 00000", err, busy, strb);
      end
      next_cycle();
      #1;
      vectors++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL div_rej_pulse: err=%b busy=%b want 0 0", err, busy);
      end
   endtask
`endif

   task automatic test_abort();
      int ndone;
      ndone = 0;
      start = 1'b1; op = 1'b0; mq35 = 1'b1;
      next_cycle();
      start = 1'b0;
      for (int i = 0; i < 3; i++) next_cycle();
      abort = 1'b1;
      #1;
      vectors++;
      if (step !== 6'd2 || strb !== 5'd0 || ad_fn !== 2'd0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_gate: step=%0d strb=%b ad_fn=%0d busy=%b want 2 00000 0 1", step, strb, ad_fn, busy);
      end
      next_cycle();
      abort = 1'b0; mq35 = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_idle: busy=%b done=%b want 0 0", busy, done);
      end
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         #1;
         if (done) ndone++;
      end
      vectors++;
      if (ndone !== 0) begin
         miscompares++;
         $display("FAIL abort_no_done: done pulses=%0d want 0", ndone);
      end
   endtask

   task automatic test_start_abort_idle();
      start = 1'b1; abort = 1'b1; op = 1'b0;
      next_cycle();
      start = 1'b0; abort = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b1 || strb !== 5'b11000) begin
         miscompares++;
         $display("FAIL start_abort_idle: busy=%b strb=%b want 1 11000", busy, strb);
      end
      for (int k = 0; k < 20 && busy; k++) next_cycle();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL start_abort_finish: busy=%b want 0 within 20 cycles", busy);
      end
   endtask

   task automatic test_reset_mid_step();
      int nstrb;
      int unsigned t0;
      start = 1'b1; op = 1'b0;
      next_cycle();
      start = 1'b0;
      for (int i = 0; i < 3; i++) next_cycle();
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, err, ad_fn, strb, step} !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_mid_step: busy=%b done=%b err=%b ad_fn=%0d strb=%b step=%0d want all 0",
                  busy, done, err, ad_fn, strb, step);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      nstrb = 0;
      start = 1'b1;
      t0 = cyc;
      next_cycle();
      start = 1'b0;
      for (int i = 0; i < 5 && !done; i++) begin
         next_cycle();
         #1;
         if (mq_shift) nstrb++;
      end
      vectors++;
      if (nstrb !== 4 || done !== 1'b1 || (cyc - t0) !== 6) begin
         miscompares++;
         $display("FAIL reset_rerun: steps=%0d done=%b latency=%0d want 4 1 6", nstrb, done, cyc - t0);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      int ndone;
      int unsigned first_done, second_done;
      ndone = 0; first_done = 0; second_done = 0;
      start = 1'b1; op = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (done) begin
            ndone++;
            if (ndone == 1) first_done = cyc;
            if (ndone == 2) second_done = cyc;
         end
         next_cycle();
      end
      start = 1'b0;
      vectors++;
      if (ndone !== 2) begin
         miscompares++;
         $display("FAIL b2b_count: done pulses=%0d want 2", ndone);
      end
      vectors++;
      if ((second_done - first_done) !== 7) begin
         miscompares++;
         $display("FAIL b2b_spacing: spacing=%0d want 7", second_done - first_done);
      end
      for (int k = 0; k < 20 && busy; k++) next_cycle();
      for (int i = 0; i < 3; i++) next_cycle();
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_no_queue: busy=%b want 0 after start released", busy);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
`ifdef EDP_MDSTEP_DIV_EN
      test_div();
`else
      test_div_disabled();
`endif
      test_abort();
      test_start_abort_idle();
      test_reset_mid_step();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
